// File: rtl/sram_model_pipe_if.sv
// -----------------------------------------------------------------------------
// sram_model_pipe_if
// Request/response bundle between a bus adapter and the pipelined SRAM model.
//
// Request channel (master -> slave, with req_ready flowing back):
//   req_valid, req_we, req_addr, req_wdata, req_wstrb ; req_ready
// Response channel (slave -> master, with resp_ready flowing back):
//   resp_valid, resp_rdata ; resp_ready
// -----------------------------------------------------------------------------
interface sram_model_pipe_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);

   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic [DATA_WIDTH/8-1:0]   req_wstrb;

   logic                      resp_valid;
   logic                      resp_ready;
   logic [DATA_WIDTH-1:0]     resp_rdata;

   // The bus adapter side issues requests and consumes responses.
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   // The memory side accepts requests and produces responses.
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/sram_model_pipe.sv
// -----------------------------------------------------------------------------
// sram_model_pipe
// Single-port synchronous SRAM model with byte write strobes, a fixed-latency
// read pipeline and a credit-limited, in-order response FIFO.
//
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - asynchronous active-high reset; clears control state only,
//          memory contents survive
//   bus  - sram_model_pipe_if.slave
//          req_*  : valid/ready request channel (read or byte-masked write)
//          resp_* : valid/ready read-data channel, responses in request order
// -----------------------------------------------------------------------------
module sram_model_pipe #(
   parameter string FILENAME   = "sram_model_pipe.hex",
   parameter int    ADDR_WIDTH = 10,
   parameter int    DATA_WIDTH = 32,
   parameter int    NWORDS     = 1 << ADDR_WIDTH,
   parameter int    LATENCY    = 1,
   parameter int    RESP_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   sram_model_pipe_if.slave bus
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

   localparam logic [ADDR_WIDTH:0] WORDS_LIMIT = (ADDR_WIDTH + 1)'(NWORDS);
   localparam logic [CNT_W-1:0]    DEPTH_CNT   = CNT_W'(RESP_DEPTH);
   localparam logic [PTR_W-1:0]    LAST_PTR    = PTR_W'(RESP_DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [NWORDS];

   logic [CNT_W-1:0]      r_outstanding;
   logic [DATA_WIDTH-1:0] r_fifoData [RESP_DEPTH];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]      r_fifoCount;

   logic                  w_accept;
   logic                  w_inRange;
   logic [IDX_W-1:0]      w_wordIdx;
   logic                  w_sampleValid;
   logic [DATA_WIDTH-1:0] w_sampleData;
   logic                  w_fifoInValid;
   logic [DATA_WIDTH-1:0] w_fifoInData;
   logic                  w_respFire;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Request side. Readiness is a pure function of the registered credit
   // count, so there is no combinational path from resp_ready to req_ready,
   // and writes are throttled by the same credit limit as reads.
   assign bus.req_ready = (r_outstanding < DEPTH_CNT);
   assign w_accept      = bus.req_valid && bus.req_ready;
   assign w_inRange     = ({1'b0, bus.req_addr} < WORDS_LIMIT);
   assign w_wordIdx     = bus.req_addr[IDX_W-1:0];

   // A read samples the array at its acceptance edge. Out-of-range reads still
   // travel the pipeline so they get a response, but carry zeros.
   assign w_sampleValid = w_accept && !bus.req_we;
   assign w_sampleData  = w_inRange ? r_mem[w_wordIdx] : '0;

   // Byte-masked write port. The array is deliberately outside the reset
   // domain so a reset mid-run keeps its contents. Out-of-range writes are
   // discarded rather than aliased onto a lower word.
   always_ff @(posedge clk) begin
      if (w_accept && bus.req_we && w_inRange) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (bus.req_wstrb[b]) begin
               r_mem[w_wordIdx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read pipeline. The sample edge itself counts as the first stage, so
   // LATENCY-1 register stages follow it before the FIFO. With LATENCY of one
   // the sampled word is pushed into the FIFO directly on the acceptance edge.
   // The credit limit guarantees FIFO room, so the pipeline never stalls.
   generate
      if (LATENCY == 1) begin : g_noPipe
         assign w_fifoInValid = w_sampleValid;
         assign w_fifoInData  = w_sampleData;
      end else begin : g_pipe
         logic [LATENCY-2:0]    r_pipeValid;
         logic [DATA_WIDTH-1:0] r_pipeData [LATENCY-1];

         // Valid bits are flushed by reset so in-flight reads vanish.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pipeValid <= '0;
            end else begin
               r_pipeValid[0] <= w_sampleValid;
               for (int s = 1; s < LATENCY - 1; s++) begin
                  r_pipeValid[s] <= r_pipeValid[s-1];
               end
            end
         end

         // Data stages only move; their value is meaningless without a valid.
         always_ff @(posedge clk) begin
            r_pipeData[0] <= w_sampleData;
            for (int s = 1; s < LATENCY - 1; s++) begin
               r_pipeData[s] <= r_pipeData[s-1];
            end
         end

         assign w_fifoInValid = r_pipeValid[LATENCY-2];
         assign w_fifoInData  = r_pipeData[LATENCY-2];
      end
   endgenerate

   // Response FIFO outputs. Read data is forced to zero while empty so the
   // bus shows a clean value during and after reset.
   assign bus.resp_valid = (r_fifoCount != '0);
   assign bus.resp_rdata = bus.resp_valid ? r_fifoData[r_rdPtr] : '0;
   assign w_respFire     = bus.resp_valid && bus.resp_ready;

   // Credit counter: one credit per accepted read, returned on the response
   // handshake. It covers reads both in the pipeline and in the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
      end else if (w_sampleValid && !w_respFire) begin
         r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (!w_sampleValid && w_respFire) begin
         r_outstanding <= r_outstanding - CNT_W'(1);
      end
   end

   // FIFO pointers and occupancy. A push and a pop in the same cycle leave the
   // occupancy unchanged. Even a push into an empty FIFO becomes visible only
   // on the next cycle; there is no bypass around the storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_fifoCount <= '0;
      end else begin
         if (w_fifoInValid) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_respFire) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         if (w_fifoInValid && !w_respFire) begin
            r_fifoCount <= r_fifoCount + CNT_W'(1);
         end else if (!w_fifoInValid && w_respFire) begin
            r_fifoCount <= r_fifoCount - CNT_W'(1);
         end
      end
   end

   // FIFO storage. Entries need no reset because the occupancy count decides
   // what is visible.
   always_ff @(posedge clk) begin
      if (w_fifoInValid) begin
         r_fifoData[r_wrPtr] <= w_fifoInData;
      end
   end

endmodule

// File: tb/tb_sram_model_pipe.sv
module tb_sram_model_pipe;

   localparam int ADDR_WIDTH = 10;
   localparam int DATA_WIDTH = 32;
   localparam int NWORDS     = 512;
   localparam int LATENCY    = 3;
   localparam int RESP_DEPTH = 4;

   typedef struct {
      logic [31:0] data;
      int          arrive;
   } respT;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sram_model_pipe_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   sram_model_pipe #(
      .FILENAME   (""),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NWORDS     (NWORDS),
      .LATENCY    (LATENCY),
      .RESP_DEPTH (RESP_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checkCount = 0;
   int passCount  = 0;

   // Behavioural reference: the memory image, a queue of reads that have been
   // accepted but not yet handed back, and the edge each one becomes visible.
   logic [31:0] modelMem [NWORDS];
   respT        modelQ [$];
   respT        newEntry;
   int          cycleNo          = 0;
   int          acceptCount      = 0;
   int          readAcceptCount  = 0;
   int          respCount        = 0;
   bit          headVisible;
   bit          modelReady;
   int          wIdx;

   logic [31:0] readData;
   int          readWait;
   logic [31:0] fillData;
   logic [9:0]  randAddr;
   int          a0;
   int          r0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      checkCount++;
      $display("[TB] FAIL %s: still waiting after cycle bound, expected completion at %0t", name, $time);
   endtask

   // Reference update on every edge: responses leave in order, each read
   // becomes visible LATENCY-1 edges after its acceptance edge, and requests
   // are accepted only while fewer than RESP_DEPTH reads are owed.
   always @(posedge clk or posedge rst) begin
      cycleNo++;
      if (rst) begin
         modelQ.delete();
      end else begin
         headVisible = (modelQ.size() > 0) && (modelQ[0].arrive <= cycleNo - 1);
         modelReady  = (modelQ.size() < RESP_DEPTH);
         if (headVisible && bus.resp_ready) begin
            void'(modelQ.pop_front());
            respCount++;
         end
         if (bus.req_valid && modelReady) begin
            acceptCount++;
            wIdx = int'(bus.req_addr);
            if (bus.req_we) begin
               if (wIdx < NWORDS) begin
                  for (int b = 0; b < 4; b++) begin
                     if (bus.req_wstrb[b]) modelMem[wIdx][8*b +: 8] = bus.req_wdata[8*b +: 8];
                  end
               end
            end else begin
               readAcceptCount++;
               newEntry.data   = (wIdx < NWORDS) ? modelMem[wIdx] : 32'h0;
               newEntry.arrive = cycleNo + LATENCY - 1;
               modelQ.push_back(newEntry);
            end
         end
      end
   end

   // Compare process: outputs are registered, so check them mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
         checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
         checkOutput("reset resp_rdata", bus.resp_rdata, 32'd0);
      end else begin
         checkOutput("req_ready", 32'(bus.req_ready), 32'(modelQ.size() < RESP_DEPTH));
         if (modelQ.size() > 0 && modelQ[0].arrive <= cycleNo) begin
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("resp_rdata", bus.resp_rdata, modelQ[0].data);
         end else begin
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'd0);
         end
      end
   end

   // Drives one request starting at the current point (just after a falling
   // edge) and holds it until an edge where the memory was ready.
   task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      logic acc;
      int   waited = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wstrb = wstrb;
      forever begin
         acc = bus.req_ready;
         @(negedge clk); #1;
         if (acc) break;
         waited++;
         if (waited > 40) begin
            reportTimeout("request accept");
            break;
         end
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic drainResponses();
      int waited = 0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      while (modelQ.size() != 0) begin
         @(negedge clk); #1;
         waited++;
         if (waited > 60) begin
            reportTimeout("drain");
            break;
         end
      end
   endtask

   task automatic readWord(input logic [9:0] addr, output logic [31:0] data, output int waited);
      data = 32'h0;
      waited = 0;
      bus.resp_ready = 1'b1;
      applyStimulus(1'b0, addr, 32'h0, 4'h0);
      while (!bus.resp_valid) begin
         @(negedge clk); #1;
         waited++;
         if (waited > 20) begin
            reportTimeout("read response");
            return;
         end
      end
      data = bus.resp_rdata;
      @(negedge clk); #1;
   endtask

   task automatic resetPulse();
      rst = 1'b1;
      #1;
      checkOutput("async reset resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("async reset req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected $finish before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;

      // Give every implemented word a known value, with two marker words.
      for (int a = 0; a < NWORDS; a++) begin
         fillData = $urandom;
         if (a == 5)  fillData = 32'hDEADBEEF;
         if (a == 88) fillData = 32'h5A5A0088;
         applyStimulus(1'b1, 10'(a), fillData, 4'hF);
      end
      drainResponses();

      // Reset keeps contents; a LATENCY-cycle read of the marker word.
      resetPulse();
      readWord(10'd5, readData, readWait);
      checkOutput("preload word 5", readData, 32'hDEADBEEF);
      checkOutput("read latency", 32'(readWait), 32'd2);

      // Byte strobes, with the read immediately after the second write.
      applyStimulus(1'b1, 10'd3, 32'h11223344, 4'b1111);
      applyStimulus(1'b1, 10'd3, 32'hAABBCCDD, 4'b0101);
      readWord(10'd3, readData, readWait);
      checkOutput("byte strobe dut", readData, 32'h11BB33DD);
      checkOutput("byte strobe model", modelMem[3], 32'h11BB33DD);

      // Backpressure: only RESP_DEPTH reads get in while resp_ready is low.
      drainResponses();
      bus.resp_ready = 1'b0;
      a0 = readAcceptCount;
      r0 = respCount;
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(1'b0, 10'(i), 32'h0, 4'h0);
         end
         begin
            repeat (10) @(negedge clk);
            #1;
            checkOutput("backpressure accepted", 32'(readAcceptCount - a0), 32'd4);
            checkOutput("backpressure req_ready", 32'(bus.req_ready), 32'd0);
            bus.resp_ready = 1'b1;
         end
      join
      drainResponses();
      checkOutput("backpressure responses", 32'(respCount - r0), 32'd6);

      // Streaming: one read per cycle, each answered LATENCY edges later.
      a0 = acceptCount;
      r0 = respCount;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b0;
         bus.req_addr  = 10'(100 + i);
         @(negedge clk); #1;
      end
      bus.req_valid = 1'b0;
      checkOutput("stream accepted", 32'(acceptCount - a0), 32'd16);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("stream responses", 32'(respCount - r0), 32'd16);

      // Out of range: the write is dropped, the read answers zero.
      drainResponses();
      applyStimulus(1'b1, 10'd600, 32'hFFFFFFFF, 4'hF);
      readWord(10'd600, readData, readWait);
      checkOutput("out of range read", readData, 32'h0);
      readWord(10'd88, readData, readWait);
      checkOutput("alias word 88", readData, 32'h5A5A0088);

      // Reset with reads in flight: they disappear, memory survives.
      bus.resp_ready = 1'b0;
      applyStimulus(1'b0, 10'd5, 32'h0, 4'h0);
      applyStimulus(1'b0, 10'd3, 32'h0, 4'h0);
      applyStimulus(1'b0, 10'd88, 32'h0, 4'h0);
      repeat (4) @(negedge clk);
      #1;
      resetPulse();
      bus.resp_ready = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      checkOutput("no stale response", 32'(bus.resp_valid), 32'd0);
      readWord(10'd5, readData, readWait);
      checkOutput("post reset word 5", readData, 32'hDEADBEEF);

      // Random traffic, mostly in a small window to hit read-after-write.
      for (int c = 0; c < 600; c++) begin
         randAddr = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
         bus.req_valid  = ($urandom_range(0, 3) != 0);
         bus.req_we     = 1'($urandom_range(0, 1));
         bus.req_addr   = randAddr;
         bus.req_wdata  = $urandom;
         bus.req_wstrb  = 4'($urandom_range(0, 15));
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk); #1;
      end
      drainResponses();
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
